lcd_text_writer: RTL and testbench
==================================

Name: lcd_text_writer

Overview:
- Initiator for the LCD controller's byte request/acknowledge interface.
- After reset, issues the LCD initialisation command sequence.
- Then accepts a character stream over a valid/ready interface and turns it into LCD data and command transfers.
- Tracks the cursor on a 2-row display and handles line wrap, newline (0x0A) and form feed/clear (0x0C) itself, so software only streams bytes.

Parameters:
- COLS, 16, visible columns per row; legal range 1..40. Row 0 base DDRAM address 0x00, row 1 base 0x40.
- INIT_LEN, 4, number of init commands. Fixed ROM contents: 0x38, 0x0C, 0x01, 0x06.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- char_in  input  8  character byte from upstream
- char_valid  input  1  char_in valid
- char_ready  output  1  writer can accept a byte this cycle
- lcd_data  output  8  byte to LCD controller (controller data_in)
- lcd_is_cmd  output  1  1 = command, 0 = DDRAM data (controller data_is_cmd)
- lcd_req  output  1  transfer request (controller data_req)
- lcd_ack  input  1  transfer acknowledge (controller data_ack)
- init_done  output  1  init sequence complete; sticky until reset
- cursor_row  output  1  current row
- cursor_col  output  clog2(COLS)  current column

Behaviour:
- Timing and reset:
  - Single clock domain; all outputs registered.
  - Reset is synchronous, active-high, taking effect at the clk edge where rst=1.
  - Reset values: lcd_req=0, lcd_data=0x00, lcd_is_cmd=0, char_ready=0, init_done=0, cursor_row=0, cursor_col=0, init index=0, state=INIT.
- Four-phase handshake (downstream), per transfer:
  - (1) Drive lcd_data and lcd_is_cmd, and set lcd_req=1 in the same cycle.
  - (2) Hold all three stable until lcd_ack=1 is sampled.
  - (3) Next cycle, lcd_req=0.
  - (4) Wait until lcd_ack=0 is sampled before any new request.
  - lcd_data and lcd_is_cmd never change while lcd_req=1.
- State machine:
  - INIT: load ROM[idx] as a command, go to REQ.
    - On return: if idx=INIT_LEN-1, set init_done=1, cursor=(0,0) and go to IDLE; else idx+1.
  - IDLE: char_ready=1.
    - On char_valid&&char_ready at edge T: latch byte, char_ready=0 from T+1, classify the byte, go to REQ with lcd_req=1 at T+1.
  - REQ: lcd_req=1; on lcd_ack=1 go to REL.
  - REL: lcd_req=0; on lcd_ack=0 go to NEXT.
  - NEXT: decide whether a follow-up command is pending (see cursor rules); if so go to REQ with it, else go to IDLE or INIT as appropriate.
- Cursor rules:
  - Printable byte (anything except 0x0A and 0x0C):
    - Send as data (is_cmd=0), col+1.
    - If col reaches COLS: col=0, row toggles, then a follow-up command 0x80|base(new row) is sent before IDLE.
    - This gives 0xC0 entering row 1 and 0x80 wrapping back to row 0.
  - 0x0A: send command 0x80|base(!row); row toggles, col=0. On row 1 this wraps to row 0 (0x80).
  - 0x0C: send command 0x01; row=0, col=0.
  - Cursor registers update when the transfer's ack is sampled, not at acceptance.
- Boundaries:
  - char_valid is ignored while char_ready=0; the upstream must hold the byte.
  - char_ready is never 1 before init_done=1.
  - lcd_ack already high when REL is entered: stay in REL; no new request until ack is seen low.
  - lcd_ack stuck low: remain in REQ indefinitely; no timeout.
  - Reset mid-transfer: lcd_req=0 the cycle after the reset edge, and init restarts from 0x38. The LCD controller shares rst, so its handshake also restarts.
  - At most one follow-up command per accepted byte.
- Size: roughly 150-250 lines.

Test Plan:
- Init, responder acks 3 cycles after req and drops ack 1 cycle after req falls:
  - Observe exactly 0x38, 0x0C, 0x01, 0x06 with is_cmd=1, in that order.
  - Each new req rises only after ack is seen low.
  - init_done=1 and char_ready=1 afterwards.
- Single byte 0x41 after init:
  - One transfer, lcd_data=0x41, is_cmd=0, lcd_req high the cycle after acceptance.
  - Ends with cursor (0,1); char_ready low throughout the transfer.
- Wrap, COLS=16:
  - 16 bytes 0x30..0x3F: 16th data transfer is followed by command 0xC0, cursor (1,0).
  - 16 more bytes: final transfer followed by command 0x80, cursor (0,0).
- Control bytes:
  - At cursor (0,5), 0x0A gives command 0xC0 and cursor (1,0).
  - Then 0x0C gives command 0x01 and cursor (0,0).
  - No data transfers occur for either byte.
- Handshake stress:
  - Ack held high 10 cycles after req falls: no new req during that window.
  - char_valid pulsed while busy: byte not taken, char_ready stays 0.
- Reset while lcd_req=1 mid-character: lcd_req=0 next cycle, init_done=0, first new request is 0x38 with is_cmd=1.

Source files
------------

// File: rtl/lcd_text_writer.sv
// Character-stream front end for the LCD byte controller: runs the init
// command sequence, then turns bytes into data/command transfers with cursor tracking.
module lcd_text_writer #(
  parameter int COLS     = 16,
  parameter int INIT_LEN = 4,
  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int IDX_W   = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  output logic             char_ready,
  output logic [7:0]       lcd_data,
  output logic             lcd_is_cmd,
  output logic             lcd_req,
  input  logic             lcd_ack,
  output logic             init_done,
  output logic             cursor_row,
  output logic [COL_W-1:0] cursor_col
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_REQ, S_REL, S_NEXT} state_t;
  // What the in-flight transfer does to the cursor once it is acknowledged.
  typedef enum logic [1:0] {K_CMD, K_PRINT, K_NL, K_FF} kind_t;

  state_t           state, state_nxt;
  kind_t            kind, kind_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             pend, pend_nxt;
  logic [7:0]       pend_cmd, pend_cmd_nxt;
  logic [7:0]       data_nxt;
  logic             is_cmd_nxt, req_nxt, ready_nxt, done_nxt, row_nxt;
  logic [COL_W-1:0] col_nxt;

  logic       accept, last_init, wrap_col;
  logic [7:0] other_row_cmd;

  function automatic logic [7:0] init_rom(input logic [IDX_W-1:0] i);
    case (int'(i))
      0:       init_rom = 8'h38;
      1:       init_rom = 8'h0C;
      2:       init_rom = 8'h01;
      3:       init_rom = 8'h06;
      default: init_rom = 8'h00;
    endcase
  endfunction

  assign accept        = char_valid && char_ready;
  assign last_init     = (idx == IDX_W'(INIT_LEN - 1));
  assign wrap_col      = (cursor_col == COL_W'(COLS - 1));
  assign other_row_cmd = cursor_row ? 8'h80 : 8'hC0;

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: state_nxt = S_REQ;
      S_IDLE: if (accept) state_nxt = S_REQ;
      S_REQ:  if (lcd_ack) state_nxt = S_REL;
      S_REL:  if (!lcd_ack) state_nxt = S_NEXT;
      S_NEXT: begin
        if (pend)                        state_nxt = S_REQ;
        else if (!init_done && !last_init) state_nxt = S_INIT;
        else                             state_nxt = S_IDLE;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    data_nxt     = lcd_data;
    is_cmd_nxt   = lcd_is_cmd;
    req_nxt      = lcd_req;
    ready_nxt    = char_ready;
    done_nxt     = init_done;
    row_nxt      = cursor_row;
    col_nxt      = cursor_col;
    idx_nxt      = idx;
    kind_nxt     = kind;
    pend_nxt     = pend;
    pend_cmd_nxt = pend_cmd;
    case (state)
      S_INIT: begin
        data_nxt   = init_rom(idx);
        is_cmd_nxt = 1'b1;
        req_nxt    = 1'b1;
        kind_nxt   = K_CMD;
      end
      S_IDLE: begin
        if (accept) begin
          ready_nxt = 1'b0;
          req_nxt   = 1'b1;
          case (char_in)
            8'h0A: begin
              data_nxt   = other_row_cmd;
              is_cmd_nxt = 1'b1;
              kind_nxt   = K_NL;
            end
            8'h0C: begin
              data_nxt   = 8'h01;
              is_cmd_nxt = 1'b1;
              kind_nxt   = K_FF;
            end
            default: begin
              data_nxt   = char_in;
              is_cmd_nxt = 1'b0;
              kind_nxt   = K_PRINT;
            end
          endcase
        end
      end
      S_REQ: begin
        if (lcd_ack) begin
          req_nxt = 1'b0;
          case (kind)
            K_PRINT: begin
              if (wrap_col) begin
                col_nxt      = '0;
                row_nxt      = ~cursor_row;
                pend_nxt     = 1'b1;
                pend_cmd_nxt = other_row_cmd;
              end else begin
                col_nxt = cursor_col + COL_W'(1);
              end
            end
            K_NL: begin
              row_nxt = ~cursor_row;
              col_nxt = '0;
            end
            K_FF: begin
              row_nxt = 1'b0;
              col_nxt = '0;
            end
            default: ;
          endcase
        end
      end
      S_NEXT: begin
        if (pend) begin
          data_nxt   = pend_cmd;
          is_cmd_nxt = 1'b1;
          req_nxt    = 1'b1;
          kind_nxt   = K_CMD;
          pend_nxt   = 1'b0;
        end else if (!init_done) begin
          if (last_init) begin
            done_nxt  = 1'b1;
            row_nxt   = 1'b0;
            col_nxt   = '0;
            ready_nxt = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else begin
          ready_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_data   <= 8'h00;
      lcd_is_cmd <= 1'b0;
      lcd_req    <= 1'b0;
      char_ready <= 1'b0;
      init_done  <= 1'b0;
      cursor_row <= 1'b0;
      cursor_col <= '0;
      idx        <= '0;
      kind       <= K_CMD;
      pend       <= 1'b0;
      pend_cmd   <= 8'h00;
    end else begin
      lcd_data   <= data_nxt;
      lcd_is_cmd <= is_cmd_nxt;
      lcd_req    <= req_nxt;
      char_ready <= ready_nxt;
      init_done  <= done_nxt;
      cursor_row <= row_nxt;
      cursor_col <= col_nxt;
      idx        <= idx_nxt;
      kind       <= kind_nxt;
      pend       <= pend_nxt;
      pend_cmd   <= pend_cmd_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed bench for lcd_text_writer with a delayed-ack LCD responder model.
module tb_lcd_text_writer;
  localparam int COLS  = 16;
  localparam int COL_W = $clog2(COLS);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       char_in = 8'h00;
  logic             char_valid = 1'b0;
  logic             char_ready;
  logic [7:0]       lcd_data;
  logic             lcd_is_cmd;
  logic             lcd_req;
  logic             lcd_ack = 1'b0;
  logic             init_done;
  logic             cursor_row;
  logic [COL_W-1:0] cursor_col;

  lcd_text_writer #(.COLS(COLS), .INIT_LEN(4)) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .lcd_data(lcd_data), .lcd_is_cmd(lcd_is_cmd),
    .lcd_req(lcd_req), .lcd_ack(lcd_ack), .init_done(init_done),
    .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder: raise ack rsp_ack_dly cycles after req, drop it rsp_rel_dly cycles after req falls.
  int rsp_ack_dly = 3;
  int rsp_rel_dly = 1;
  int rsp_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      lcd_ack = 1'b0;
      rsp_cnt = 0;
    end else if (!lcd_ack) begin
      if (lcd_req) begin
        if (rsp_cnt == rsp_ack_dly - 1) begin lcd_ack = 1'b1; rsp_cnt = 0; end
        else rsp_cnt++;
      end else rsp_cnt = 0;
    end else if (!lcd_req) begin
      if (rsp_cnt == rsp_rel_dly - 1) begin lcd_ack = 1'b0; rsp_cnt = 0; end
      else rsp_cnt++;
    end
  end

  logic       prev_req = 1'b0;
  logic [8:0] prev_x = 9'h000;
  logic [8:0] xq[$];
  int stab_err = 0, ack_rise_err = 0, ready_busy_err = 0;
  always @(posedge clk) begin
    #1;
    if (lcd_req && !prev_req) begin
      xq.push_back({lcd_is_cmd, lcd_data});
      if (lcd_ack) ack_rise_err++;
    end
    if (lcd_req && prev_req && ({lcd_is_cmd, lcd_data} != prev_x)) stab_err++;
    if (lcd_req && char_ready) ready_busy_err++;
    prev_req = lcd_req;
    prev_x   = {lcd_is_cmd, lcd_data};
  end

  function automatic logic [8:0] xq_at(input int i);
    return (i < xq.size()) ? xq[i] : 9'h1FF;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (n < budget) begin
      @(posedge clk); #1;
      if (char_ready) break;
      n++;
    end
    if (n >= budget) check("idle_timeout", 0, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    char_in = b; char_valid = 1'b1;
    @(posedge clk); #1;
    char_valid = 1'b0;
    check("req_after_accept", 32'(lcd_req), 1);
    check("ready_drop", 32'(char_ready), 0);
  endtask

  task automatic send_wait(input logic [7:0] b);
    send_byte(b);
    wait_idle(100);
  endtask

  task automatic check_cursor(input string tag, input int r, input int c);
    check({tag, "_row"}, 32'(cursor_row), r);
    check({tag, "_col"}, 32'(cursor_col), c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int busy_req, busy_rdy;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(lcd_req), 0);
    check("rst_data", 32'(lcd_data), 0);
    check("rst_is_cmd", 32'(lcd_is_cmd), 0);
    check("rst_ready", 32'(char_ready), 0);
    check("rst_done", 32'(init_done), 0);
    check_cursor("rst", 0, 0);
    rst = 1'b0;

    wait_idle(300);
    check("init_count", xq.size(), 4);
    check("init_0", 32'(xq_at(0)), 9'h138);
    check("init_1", 32'(xq_at(1)), 9'h10C);
    check("init_2", 32'(xq_at(2)), 9'h101);
    check("init_3", 32'(xq_at(3)), 9'h106);
    check("init_done", 32'(init_done), 1);
    check("init_ready", 32'(char_ready), 1);

    xq.delete();
    send_wait(8'h41);
    check("single_count", xq.size(), 1);
    check("single_xfer", 32'(xq_at(0)), 9'h041);
    check_cursor("single", 0, 1);

    xq.delete();
    send_wait(8'h0C);
    check("clr_xfer", 32'(xq_at(0)), 9'h101);
    check_cursor("clr", 0, 0);

    xq.delete();
    for (int i = 0; i < 16; i++) send_wait(8'(8'h30 + i));
    check("wrap1_count", xq.size(), 17);
    check("wrap1_first", 32'(xq_at(0)), 9'h030);
    check("wrap1_last", 32'(xq_at(15)), 9'h03F);
    check("wrap1_cmd", 32'(xq_at(16)), 9'h1C0);
    check_cursor("wrap1", 1, 0);

    xq.delete();
    for (int i = 0; i < 16; i++) send_wait(8'(8'h30 + i));
    check("wrap2_count", xq.size(), 17);
    check("wrap2_cmd", 32'(xq_at(16)), 9'h180);
    check_cursor("wrap2", 0, 0);

    for (int i = 0; i < 5; i++) send_wait(8'(8'h61 + i));
    check_cursor("pre_nl", 0, 5);
    xq.delete();
    send_wait(8'h0A);
    check("nl_count", xq.size(), 1);
    check("nl_cmd", 32'(xq_at(0)), 9'h1C0);
    check_cursor("nl", 1, 0);
    xq.delete();
    send_wait(8'h0C);
    check("ff_count", xq.size(), 1);
    check("ff_cmd", 32'(xq_at(0)), 9'h101);
    check_cursor("ff", 0, 0);

    for (int i = 0; i < 15; i++) send_wait(8'(8'h61 + i));
    check_cursor("pre_stress", 0, 15);
    rsp_rel_dly = 10;
    xq.delete();
    send_byte(8'h42);
    n = 0;
    while (lcd_req && n < 20) begin @(posedge clk); #1; n++; end
    check("stress_req_fall", 32'(lcd_req), 0);
    busy_req = 0; busy_rdy = 0;
    char_in = 8'h55; char_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (lcd_req) busy_req++;
      if (char_ready) busy_rdy++;
    end
    char_valid = 1'b0;
    check("stress_no_req_ack_high", busy_req, 0);
    check("stress_ready_busy", busy_rdy, 0);
    wait_idle(100);
    check("stress_count", xq.size(), 2);
    check("stress_data", 32'(xq_at(0)), 9'h042);
    check("stress_cmd", 32'(xq_at(1)), 9'h1C0);
    check_cursor("stress", 1, 0);
    rsp_rel_dly = 1;

    send_byte(8'h43);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_req", 32'(lcd_req), 0);
    check("mid_rst_done", 32'(init_done), 0);
    check("mid_rst_ready", 32'(char_ready), 0);
    check_cursor("mid_rst", 0, 0);
    rst = 1'b0;
    xq.delete();
    wait_idle(300);
    check("reinit_count", xq.size(), 4);
    check("reinit_first", 32'(xq_at(0)), 9'h138);
    check("reinit_done", 32'(init_done), 1);

    check("data_stable_during_req", stab_err, 0);
    check("req_rise_ack_low", ack_rise_err, 0);
    check("ready_low_while_req", ready_busy_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
